// File: rtl/axi_burst_initiator.sv
// AXI4 type package and a single-outstanding INCR burst manager.
// One command becomes one AW/W/B or AR/R burst with a merged response.
package axi_pkg;
    typedef logic [7:0] len_t;
    typedef logic [1:0] resp_t;
    typedef logic [2:0] size_t;
    typedef logic [1:0] burst_t;

    localparam resp_t RESP_OKAY = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;
    localparam burst_t BURST_INCR = 2'b01;

    typedef struct packed {
        logic [3:0] id;
        logic [31:0] addr;
        len_t len;
        size_t size;
        burst_t burst;
        logic lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        logic [5:0] atop;
        logic [0:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0] strb;
        logic last;
        logic [0:0] user;
    } w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        resp_t resp;
        logic [0:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [31:0] addr;
        len_t len;
        size_t size;
        burst_t burst;
        logic lock;
        logic [3:0] cache;
        logic [2:0] prot;
        logic [3:0] qos;
        logic [3:0] region;
        logic [0:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [63:0] data;
        resp_t resp;
        logic last;
        logic [0:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic aw_valid;
        w_chan_t w;
        logic w_valid;
        logic b_ready;
        ar_chan_t ar;
        logic ar_valid;
        logic r_ready;
    } axi_req_t;

    typedef struct packed {
        logic aw_ready;
        logic ar_ready;
        logic w_ready;
        logic b_valid;
        b_chan_t b;
        logic r_valid;
        r_chan_t r;
    } axi_rsp_t;

    // Worse of two responses: DECERR > SLVERR > OKAY > EXOKAY.
    function automatic resp_t resp_precedence(resp_t a, resp_t b);
        resp_t res;
        unique case (a)
            RESP_OKAY: res = (b == RESP_EXOKAY) ? a : b;
            RESP_EXOKAY: res = b;
            RESP_SLVERR: res = (b == RESP_DECERR) ? b : a;
            default: res = a;
        endcase
        return res;
    endfunction
endpackage

module axi_burst_initiator #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdWidth = 4,
    parameter int unsigned UserWidth = 1,
    parameter logic [IdWidth-1:0] AxiId = '0,
    parameter type axi_req_t = axi_pkg::axi_req_t,
    parameter type axi_rsp_t = axi_pkg::axi_rsp_t,
    localparam int unsigned StrbWidth = DataWidth / 8
) (
    input logic clk_i,
    input logic rst_ni,
    input logic cmd_valid_i,
    output logic cmd_ready_o,
    input logic cmd_write_i,
    input logic [AddrWidth-1:0] cmd_addr_i,
    input logic [7:0] cmd_len_i,
    input logic wdata_valid_i,
    output logic wdata_ready_o,
    input logic [DataWidth-1:0] wdata_i,
    input logic [StrbWidth-1:0] wstrb_i,
    output logic rdata_valid_o,
    input logic rdata_ready_i,
    output logic [DataWidth-1:0] rdata_o,
    output logic rdata_last_o,
    output logic rsp_valid_o,
    input logic rsp_ready_i,
    output logic [1:0] rsp_resp_o,
    output axi_req_t axi_req_o,
    input axi_rsp_t axi_rsp_i
);
    import axi_pkg::*;

    localparam int unsigned SizeLog = $clog2(StrbWidth);

    typedef enum logic [2:0] {
        ST_IDLE, ST_AW, ST_W, ST_B, ST_AR, ST_R, ST_RSP
    } state_e;

    state_e state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    len_t len_q, len_d;
    len_t cnt_q, cnt_d;
    resp_t acc_q, acc_d;

    logic [AddrWidth-1:0] cmd_addr_al;
    logic [31:0] page_end;
    logic crosses;
    logic cnt_at_len;
    logic unused_user;

    assign cmd_addr_al = cmd_addr_i & ~AddrWidth'(StrbWidth - 1);
    assign page_end = 32'(cmd_addr_al[11:0])
                    + (32'(cmd_len_i) + 32'd1) * 32'(StrbWidth);
    assign crosses = page_end > 32'd4096;
    assign cnt_at_len = cnt_q == len_q;
    assign unused_user = ^{axi_rsp_i.b.user, axi_rsp_i.r.user};

    // State and burst context registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            addr_q <= '0;
            len_q <= '0;
            cnt_q <= '0;
            acc_q <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            len_q <= len_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

    // Next-state, response merging and channel steering.
    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        len_d = len_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        cmd_ready_o = 1'b0;
        wdata_ready_o = 1'b0;
        rdata_valid_o = 1'b0;
        rdata_o = axi_rsp_i.r.data;
        rdata_last_o = axi_rsp_i.r.last;
        rsp_valid_o = 1'b0;
        rsp_resp_o = acc_q;
        axi_req_o = '0;
        unique case (state_q)
            ST_IDLE: begin
                cmd_ready_o = rst_ni;
                if (cmd_valid_i) begin
                    addr_d = cmd_addr_al;
                    len_d = cmd_len_i;
                    cnt_d = '0;
                    acc_d = RESP_OKAY;
                    if (crosses) begin
                        acc_d = RESP_SLVERR;
                        state_d = ST_RSP;
                    end else begin
                        state_d = cmd_write_i ? ST_AW : ST_AR;
                    end
                end
            end
            ST_AW: begin
                axi_req_o.aw_valid = 1'b1;
                axi_req_o.aw.id = AxiId;
                axi_req_o.aw.addr = addr_q;
                axi_req_o.aw.len = len_q;
                axi_req_o.aw.size = size_t'(SizeLog);
                axi_req_o.aw.burst = BURST_INCR;
                axi_req_o.aw.user = UserWidth'(0);
                if (axi_rsp_i.aw_ready) state_d = ST_W;
            end
            ST_W: begin
                axi_req_o.w_valid = wdata_valid_i;
                axi_req_o.w.data = wdata_i;
                axi_req_o.w.strb = wstrb_i;
                axi_req_o.w.last = cnt_at_len;
                axi_req_o.w.user = UserWidth'(0);
                wdata_ready_o = axi_rsp_i.w_ready;
                if (wdata_valid_i && axi_rsp_i.w_ready) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_at_len) state_d = ST_B;
                end
            end
            ST_B: begin
                axi_req_o.b_ready = 1'b1;
                if (axi_rsp_i.b_valid) begin
                    acc_d = resp_precedence(axi_rsp_i.b.resp, acc_q);
                    if (axi_rsp_i.b.id != AxiId)
                        acc_d = resp_precedence(RESP_SLVERR, acc_d);
                    state_d = ST_RSP;
                end
            end
            ST_AR: begin
                axi_req_o.ar_valid = 1'b1;
                axi_req_o.ar.id = AxiId;
                axi_req_o.ar.addr = addr_q;
                axi_req_o.ar.len = len_q;
                axi_req_o.ar.size = size_t'(SizeLog);
                axi_req_o.ar.burst = BURST_INCR;
                axi_req_o.ar.user = UserWidth'(0);
                if (axi_rsp_i.ar_ready) state_d = ST_R;
            end
            ST_R: begin
                axi_req_o.r_ready = rdata_ready_i;
                rdata_valid_o = axi_rsp_i.r_valid;
                if (axi_rsp_i.r_valid && rdata_ready_i) begin
                    acc_d = resp_precedence(axi_rsp_i.r.resp, acc_q);
                    if (axi_rsp_i.r.id != AxiId
                        || axi_rsp_i.r.last != cnt_at_len)
                        acc_d = resp_precedence(RESP_SLVERR, acc_d);
                    if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                    if (axi_rsp_i.r.last) state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_burst_initiator.sv
// Bench for axi_burst_initiator: in-bench AXI subordinate and client,
// expectations from a behavioural burst/response model.
module tb_axi_burst_initiator;
    import axi_pkg::*;

    localparam logic [3:0] ID = 4'd0;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic cmd_valid_i, cmd_ready_o, cmd_write_i;
    logic [31:0] cmd_addr_i;
    logic [7:0] cmd_len_i;
    logic wdata_valid_i, wdata_ready_o;
    logic [63:0] wdata_i;
    logic [7:0] wstrb_i;
    logic rdata_valid_o, rdata_ready_i, rdata_last_o;
    logic [63:0] rdata_o;
    logic rsp_valid_o, rsp_ready_i;
    logic [1:0] rsp_resp_o;
    axi_req_t axi_req;
    axi_rsp_t axi_rsp;

    always #5 clk_i = ~clk_i;

    axi_burst_initiator dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i),
        .cmd_len_i(cmd_len_i),
        .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
        .wdata_i(wdata_i), .wstrb_i(wstrb_i),
        .rdata_valid_o(rdata_valid_o), .rdata_ready_i(rdata_ready_i),
        .rdata_o(rdata_o), .rdata_last_o(rdata_last_o),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_resp_o(rsp_resp_o),
        .axi_req_o(axi_req), .axi_rsp_i(axi_rsp)
    );

    int n_checks = 0;
    int n_fail = 0;

    logic cfg_write;
    logic [31:0] cfg_addr;
    logic [7:0] cfg_len;
    bit cfg_zero_wait;
    int cfg_rr_mode;
    int cfg_last_idx;
    int cfg_abort_beat;
    logic [1:0] cfg_bresp;
    logic [3:0] cfg_bid;
    logic [1:0] cfg_rresp [256];
    logic [63:0] cfg_rdata [256];
    logic [63:0] cfg_wdata [256];
    logic [7:0] cfg_wstrb [256];

    int ob_aw_cnt, ob_ar_cnt, ob_avalid_seen, ob_w_early;
    int ob_rr_bad, ob_lat, ob_timeout;
    bit ob_rsp_seen;
    aw_chan_t ob_aw;
    ar_chan_t ob_ar;
    logic [63:0] ob_wd [$];
    logic [7:0] ob_ws [$];
    logic ob_wl [$];
    logic [63:0] ob_rd [$];
    logic ob_rl [$];
    logic [1:0] ob_resp;

    function automatic int rank(logic [1:0] r);
        case (r)
            2'b11: return 3;
            2'b10: return 2;
            2'b00: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [1:0] worst(logic [1:0] a, logic [1:0] b);
        return (rank(a) >= rank(b)) ? a : b;
    endfunction

    function automatic bit crosses_4k(logic [31:0] a, logic [7:0] l);
        int off;
        off = int'(a % 4096) / 8 * 8;
        return off + (int'(l) + 1) * 8 > 4096;
    endfunction

    task automatic idle_inputs();
        cmd_valid_i = 0; cmd_write_i = 0; cmd_addr_i = '0; cmd_len_i = '0;
        wdata_valid_i = 0; wdata_i = '0; wstrb_i = '0;
        rdata_ready_i = 0; rsp_ready_i = 0;
        axi_rsp = '0;
    endtask

    task automatic setup_cmd(logic w, logic [31:0] a, logic [7:0] l);
        cfg_write = w; cfg_addr = a; cfg_len = l;
        cfg_zero_wait = 1; cfg_rr_mode = 0;
        cfg_last_idx = int'(l); cfg_abort_beat = -1;
        cfg_bresp = RESP_OKAY; cfg_bid = ID;
        for (int i = 0; i < 256; i++) begin
            cfg_rresp[i] = RESP_OKAY;
            cfg_rdata[i] = {$urandom, $urandom};
            cfg_wdata[i] = {$urandom, $urandom};
            cfg_wstrb[i] = 8'($urandom);
        end
    endtask

    task automatic run_cmd();
        int cyc = 0, hs_cyc = 0, widx = 0, wseen = 0, ridx = 0;
        bit cmd_done = 0, aw_done = 0, ar_done = 0, b_pend = 0;
        bit r_done = 0, fin = 0;
        ob_aw_cnt = 0; ob_ar_cnt = 0; ob_avalid_seen = 0; ob_w_early = 0;
        ob_rr_bad = 0; ob_lat = -1; ob_timeout = 0; ob_rsp_seen = 0;
        ob_aw = '0; ob_ar = '0; ob_resp = 2'bxx;
        ob_wd.delete(); ob_ws.delete(); ob_wl.delete();
        ob_rd.delete(); ob_rl.delete();
        while (!fin && cyc < 2000) begin
            cmd_valid_i = !cmd_done;
            cmd_write_i = cfg_write;
            cmd_addr_i = cfg_addr;
            cmd_len_i = cfg_len;
            axi_rsp = '0;
            axi_rsp.aw_ready = cfg_zero_wait | 1'($urandom_range(0, 1));
            axi_rsp.ar_ready = cfg_zero_wait | 1'($urandom_range(0, 1));
            axi_rsp.w_ready = cfg_zero_wait | 1'($urandom_range(0, 1));
            wdata_valid_i = (widx <= int'(cfg_len))
                && (cfg_zero_wait || $urandom_range(0, 1) == 1);
            wdata_i = cfg_wdata[widx % 256];
            wstrb_i = cfg_wstrb[widx % 256];
            axi_rsp.b_valid = b_pend;
            axi_rsp.b.resp = cfg_bresp;
            axi_rsp.b.id = cfg_bid;
            axi_rsp.r_valid = ar_done && !r_done
                && (cfg_zero_wait || $urandom_range(0, 1) == 1);
            axi_rsp.r.data = cfg_rdata[ridx % 256];
            axi_rsp.r.resp = cfg_rresp[ridx % 256];
            axi_rsp.r.last = (ridx == cfg_last_idx);
            axi_rsp.r.id = ID;
            case (cfg_rr_mode)
                0: rdata_ready_i = 1;
                1: rdata_ready_i = 1'(cyc & 1);
                default: rdata_ready_i = 1'($urandom_range(0, 1));
            endcase
            rsp_ready_i = cfg_zero_wait | 1'($urandom_range(0, 1));
            if (cfg_abort_beat >= 0 && wseen >= cfg_abort_beat) begin
                wdata_valid_i = 1;
                #1;
                break;
            end
            #1;
            if (cmd_valid_i && cmd_ready_o) begin
                cmd_done = 1; hs_cyc = cyc;
            end
            if (axi_req.aw_valid || axi_req.ar_valid) ob_avalid_seen++;
            if (axi_req.w_valid && !aw_done) ob_w_early++;
            if (ar_done && !r_done && axi_req.r_ready !== rdata_ready_i)
                ob_rr_bad++;
            if (axi_req.aw_valid && axi_rsp.aw_ready) begin
                ob_aw_cnt++; ob_aw = axi_req.aw; aw_done = 1;
            end
            if (axi_req.ar_valid && axi_rsp.ar_ready) begin
                ob_ar_cnt++; ob_ar = axi_req.ar; ar_done = 1;
            end
            if (wdata_valid_i && wdata_ready_o) widx++;
            if (axi_req.w_valid && axi_rsp.w_ready) begin
                ob_wd.push_back(axi_req.w.data);
                ob_ws.push_back(axi_req.w.strb);
                ob_wl.push_back(axi_req.w.last);
                wseen++;
                if (wseen == int'(cfg_len) + 1) b_pend = 1;
            end
            if (axi_rsp.b_valid && axi_req.b_ready) b_pend = 0;
            if (rdata_valid_o && rdata_ready_i) begin
                ob_rd.push_back(rdata_o);
                ob_rl.push_back(rdata_last_o);
            end
            if (axi_rsp.r_valid && axi_req.r_ready) begin
                if (axi_rsp.r.last) r_done = 1;
                ridx++;
            end
            if (rsp_valid_o && !ob_rsp_seen) begin
                ob_rsp_seen = 1; ob_lat = cyc - hs_cyc;
            end
            if (rsp_valid_o && rsp_ready_i) begin
                ob_resp = rsp_resp_o; fin = 1;
            end
            @(posedge clk_i); #1;
            cyc++;
        end
        if (fin) idle_inputs();
        else if (cfg_abort_beat < 0) ob_timeout = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_ni = 0;
        #12;
        n_checks++;
        if ({cmd_ready_o, rsp_valid_o, wdata_ready_o, rdata_valid_o} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_vr: got %b required 0000",
                {cmd_ready_o, rsp_valid_o, wdata_ready_o, rdata_valid_o});
        end
        n_checks++;
        if (axi_req !== '0 || rsp_resp_o !== RESP_OKAY) begin
            n_fail++;
            $display("FAIL reset_req: got %h resp %h required 0", axi_req, rsp_resp_o);
        end
        @(negedge clk_i); rst_ni = 1;
        @(posedge clk_i); #1;
        n_checks++;
        if (cmd_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready_o);
        end
    endtask

    task automatic test_write_burst();
        int bad = 0;
        setup_cmd(1, 32'h1000, 8'd3);
        for (int i = 0; i < 4; i++) cfg_wstrb[i] = 8'hFF;
        run_cmd();
        n_checks++;
        if (ob_timeout != 0 || ob_aw_cnt != 1 || ob_ar_cnt != 0) begin
            n_fail++;
            $display("FAIL wr_aw_count: timeout %0d aw %0d ar %0d required 0 1 0",
                ob_timeout, ob_aw_cnt, ob_ar_cnt);
        end
        n_checks++;
        if (ob_aw.addr !== 32'h1000 || ob_aw.len !== 8'd3 || ob_aw.size !== 3'd3
            || ob_aw.burst !== BURST_INCR || ob_aw.id !== ID) begin
            n_fail++;
            $display("FAIL wr_aw_fields: addr %h len %0d size %0d burst %0d id %0d required 1000 3 3 1 0",
                ob_aw.addr, ob_aw.len, ob_aw.size, ob_aw.burst, ob_aw.id);
        end
        n_checks++;
        if ({ob_aw.lock, ob_aw.cache, ob_aw.prot, ob_aw.qos, ob_aw.region, ob_aw.atop} !== '0) begin
            n_fail++;
            $display("FAIL wr_aw_attr: got nonzero attributes, required 0");
        end
        n_checks++;
        if (ob_wd.size() != 4) begin
            n_fail++;
            $display("FAIL wr_beats: got %0d required 4", ob_wd.size());
        end
        for (int i = 0; i < ob_wd.size() && i < 4; i++)
            if (ob_wd[i] !== cfg_wdata[i] || ob_ws[i] !== 8'hFF || ob_wl[i] !== (i == 3))
                bad++;
        n_checks++;
        if (bad != 0 || ob_w_early != 0) begin
            n_fail++;
            $display("FAIL wr_wbeats: %0d bad beats %0d early W, required 0 0", bad, ob_w_early);
        end
        n_checks++;
        if (ob_resp !== RESP_OKAY) begin
            n_fail++;
            $display("FAIL wr_resp: got %0d required 0", ob_resp);
        end
        setup_cmd(1, 32'h3000, 8'd0);
        run_cmd();
        n_checks++;
        if (ob_lat != 4 || ob_resp !== RESP_OKAY) begin
            n_fail++;
            $display("FAIL wr_latency: got %0d resp %0d required 4 0", ob_lat, ob_resp);
        end
    endtask

    task automatic test_read_aligned();
        setup_cmd(0, 32'h2004, 8'd0);
        run_cmd();
        n_checks++;
        if (ob_ar_cnt != 1 || ob_ar.addr !== 32'h2000 || ob_ar.len !== 8'd0
            || ob_ar.size !== 3'd3 || ob_aw_cnt != 0) begin
            n_fail++;
            $display("FAIL rd_ar: cnt %0d addr %h len %0d aw %0d required 1 2000 0 0",
                ob_ar_cnt, ob_ar.addr, ob_ar.len, ob_aw_cnt);
        end
        n_checks++;
        if (ob_rd.size() != 1 || ob_rd[0] !== cfg_rdata[0] || ob_rl[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_beat: count %0d required 1 beat with last", ob_rd.size());
        end
        n_checks++;
        if (ob_resp !== RESP_OKAY || ob_lat != 3) begin
            n_fail++;
            $display("FAIL rd_resp_lat: got %0d lat %0d required 0 3", ob_resp, ob_lat);
        end
    endtask

    task automatic test_read_slverr_toggle();
        int bad = 0;
        setup_cmd(0, 32'h4000, 8'd7);
        cfg_rresp[2] = RESP_SLVERR;
        cfg_rr_mode = 1;
        run_cmd();
        n_checks++;
        if (ob_rd.size() != 8 || ob_timeout != 0) begin
            n_fail++;
            $display("FAIL rdtog_beats: got %0d required 8", ob_rd.size());
        end
        for (int i = 0; i < ob_rd.size() && i < 8; i++)
            if (ob_rd[i] !== cfg_rdata[i] || ob_rl[i] !== (i == 7)) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rdtog_order: %0d bad beats required 0", bad);
        end
        n_checks++;
        if (ob_rr_bad != 0) begin
            n_fail++;
            $display("FAIL rdtog_rready: %0d mirror errors required 0", ob_rr_bad);
        end
        n_checks++;
        if (ob_resp !== RESP_SLVERR) begin
            n_fail++;
            $display("FAIL rdtog_resp: got %0d required 2", ob_resp);
        end
    endtask

    task automatic test_4k_cross();
        for (int w = 0; w < 2; w++) begin
            setup_cmd(1'(w), 32'h0FF8, 8'd1);
            run_cmd();
            n_checks++;
            if (ob_avalid_seen != 0 || ob_wd.size() != 0) begin
                n_fail++;
                $display("FAIL x4k_traffic: write %0d avalid %0d wbeats %0d required 0 0",
                    w, ob_avalid_seen, ob_wd.size());
            end
            n_checks++;
            if (ob_lat != 1 || ob_resp !== RESP_SLVERR) begin
                n_fail++;
                $display("FAIL x4k_rsp: write %0d lat %0d resp %0d required 1 2",
                    w, ob_lat, ob_resp);
            end
        end
    endtask

    task automatic test_early_last();
        setup_cmd(0, 32'h5000, 8'd3);
        cfg_last_idx = 1;
        run_cmd();
        n_checks++;
        if (ob_rd.size() != 2 || ob_timeout != 0) begin
            n_fail++;
            $display("FAIL early_beats: got %0d required 2", ob_rd.size());
        end else begin
            n_checks++;
            if (ob_rl[1] !== 1'b1 || ob_rd[1] !== cfg_rdata[1]) begin
                n_fail++;
                $display("FAIL early_last: last %b required 1", ob_rl[1]);
            end
        end
        n_checks++;
        if (ob_resp !== RESP_SLVERR) begin
            n_fail++;
            $display("FAIL early_resp: got %0d required 2", ob_resp);
        end
    endtask

    task automatic test_reset_midburst();
        int bad = 0;
        setup_cmd(1, 32'h6000, 8'd7);
        cfg_abort_beat = 3;
        run_cmd();
        n_checks++;
        if (axi_req.w_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_wvalid_pre: got %b required 1", axi_req.w_valid);
        end
        #2 rst_ni = 0;
        #1;
        n_checks++;
        if ({axi_req.w_valid, axi_req.aw_valid, rsp_valid_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_async: w %b aw %b rsp %b required 000",
                axi_req.w_valid, axi_req.aw_valid, rsp_valid_o);
        end
        idle_inputs();
        #3 rst_ni = 1;
        @(posedge clk_i); #1;
        n_checks++;
        if (cmd_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_cmd_ready: got %b required 1", cmd_ready_o);
        end
        setup_cmd(0, 32'h7000, 8'd2);
        run_cmd();
        for (int i = 0; i < ob_rd.size() && i < 3; i++)
            if (ob_rd[i] !== cfg_rdata[i]) bad++;
        n_checks++;
        if (ob_resp !== RESP_OKAY || ob_rd.size() != 3 || bad != 0) begin
            n_fail++;
            $display("FAIL mid_read_after: resp %0d beats %0d bad %0d required 0 3 0",
                ob_resp, ob_rd.size(), bad);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            logic [31:0] a;
            logic [7:0] l;
            logic [1:0] exp;
            int bad = 0;
            l = 8'($urandom_range(0, 15));
            a = $urandom;
            if ($urandom_range(0, 3) == 0)
                a[11:0] = 12'(4096 - $urandom_range(1, 20) * 8 + $urandom_range(0, 7));
            setup_cmd(1'($urandom_range(0, 1)), a, l);
            cfg_zero_wait = 0;
            cfg_rr_mode = 2;
            cfg_bresp = 2'($urandom);
            if ($urandom_range(0, 7) == 0) cfg_bid = 4'd9;
            for (int i = 0; i < 256; i++) cfg_rresp[i] = 2'($urandom);
            run_cmd();
            exp = RESP_OKAY;
            if (crosses_4k(a, l)) begin
                exp = RESP_SLVERR;
                n_checks++;
                if (ob_avalid_seen != 0) begin
                    n_fail++;
                    $display("FAIL rnd%0d_cross: avalid seen %0d required 0", n, ob_avalid_seen);
                end
            end else if (cfg_write) begin
                exp = worst(cfg_bresp, exp);
                if (cfg_bid != ID) exp = worst(RESP_SLVERR, exp);
                if (ob_wd.size() != int'(l) + 1) bad++;
                for (int i = 0; i < ob_wd.size() && i <= int'(l); i++)
                    if (ob_wd[i] !== cfg_wdata[i] || ob_ws[i] !== cfg_wstrb[i]
                        || ob_wl[i] !== (i == int'(l))) bad++;
                n_checks++;
                if (bad != 0 || ob_aw.addr !== {a[31:3], 3'b000}
                    || ob_aw.len !== l || ob_w_early != 0) begin
                    n_fail++;
                    $display("FAIL rnd%0d_write: bad %0d addr %h len %0d required %h %0d",
                        n, bad, ob_aw.addr, ob_aw.len, {a[31:3], 3'b000}, l);
                end
            end else begin
                for (int i = 0; i <= int'(l); i++) exp = worst(cfg_rresp[i], exp);
                if (ob_rd.size() != int'(l) + 1) bad++;
                for (int i = 0; i < ob_rd.size() && i <= int'(l); i++)
                    if (ob_rd[i] !== cfg_rdata[i] || ob_rl[i] !== (i == int'(l))) bad++;
                n_checks++;
                if (bad != 0 || ob_ar.addr !== {a[31:3], 3'b000}
                    || ob_ar.len !== l || ob_rr_bad != 0) begin
                    n_fail++;
                    $display("FAIL rnd%0d_read: bad %0d addr %h len %0d rr %0d required %h %0d",
                        n, bad, ob_ar.addr, ob_ar.len, ob_rr_bad, {a[31:3], 3'b000}, l);
                end
            end
            n_checks++;
            if (ob_timeout != 0 || ob_resp !== exp) begin
                n_fail++;
                $display("FAIL rnd%0d_resp: got %0d timeout %0d required %0d",
                    n, ob_resp, ob_timeout, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_aligned();
        test_read_slverr_toggle();
        test_4k_cross();
        test_early_last();
        test_reset_midburst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_burst_initiator.md
Name: axi_burst_initiator

Overview:
- Synthesizable AXI4 manager that turns one command into one INCR burst, read or write, on a struct-typed AXI port.
- Sits on the other end of the team's AXI subordinate models and memories, for example as a DMA-lite engine or a testbench stimulus driver.
- One transaction is in flight at a time.
- Streams data between simple valid/ready ports and the AXI W or R channel, and returns a single merged response per command.

Parameters:
- AddrWidth, 32, AXI address width.
- DataWidth, 64, AXI data width; StrbWidth = DataWidth/8.
- IdWidth, 4, AXI ID width.
- UserWidth, 1, AXI user width; all user fields are driven 0.
- AxiId, 0, ID placed on AW and AR.
- axi_req_t, logic, AXI4 request struct type.
- axi_rsp_t, logic, AXI4 response struct type.

Ports:
- clk_i  in  1  rising-edge clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted (IDLE only).
- cmd_write_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  AddrWidth  start address; low log2(StrbWidth) bits are forced to 0.
- cmd_len_i  in  8  axi_pkg::len_t, beats minus 1.
- wdata_valid_i  in  1  write beat valid.
- wdata_ready_o  out  1  write beat accepted.
- wdata_i  in  DataWidth  write data.
- wstrb_i  in  StrbWidth  write strobes.
- rdata_valid_o  out  1  read beat valid.
- rdata_ready_i  in  1  read beat accepted.
- rdata_o  out  DataWidth  read data.
- rdata_last_o  out  1  final beat of the burst.
- rsp_valid_o  out  1  command completion valid.
- rsp_ready_i  in  1  completion accepted.
- rsp_resp_o  out  2  axi_pkg::resp_t merged response.
- axi_req_o  out  axi_req_t  AXI request.
- axi_rsp_i  in  axi_rsp_t  AXI response.

Behaviour:
- Reset state:
  - FSM = IDLE, beat counter = 0, accumulated resp = OKAY.
  - All valid and ready outputs are 0, axi_req_o = '0, rsp_resp_o = OKAY.
  - A reset mid-burst abandons the transaction immediately, with no draining.
- FSM states: IDLE, AW, W, B, AR, R, RSP.
- IDLE:
  - cmd_ready_o = 1.
  - On a handshake, register write, aligned address and len; clear the counter and accumulated resp.
  - 4 KiB check: aligned addr[11:0] + (len+1)*StrbWidth > 4096 means the burst crosses a boundary. Such a command goes straight to RSP with SLVERR, and no AXI traffic is issued.
  - Otherwise go to AW when write=1, or AR when write=0.
- Address beat (AW or AR):
  - Fields: id = AxiId, addr = registered address, len = registered len, size = log2(StrbWidth), burst = INCR.
  - cache, prot, qos, region, lock and atop are all 0.
  - aw_valid or ar_valid is held registered until the ready handshake; the request fields stay stable while valid is high.
  - On the handshake, AW goes to W and AR goes to R.
- W:
  - w_valid = wdata_valid_i and wdata_ready_o = w_ready, combinational pass-through.
  - w.data = wdata_i, w.strb = wstrb_i, w.last = (counter == len).
  - Each handshake increments the counter. The handshake on the last beat goes to B.
  - W is never asserted before the AW handshake completes.
- B:
  - b_ready = 1.
  - On b_valid, acc = resp_precedence(b.resp, acc). If b.id != AxiId, acc = resp_precedence(SLVERR, acc).
  - Then go to RSP.
- R:
  - rdata_valid_o = r_valid and r_ready = rdata_ready_i, combinational.
  - rdata_o = r.data, rdata_last_o = r.last.
  - Each handshake:
    - acc = resp_precedence(r.resp, acc);
    - SLVERR is merged into acc if r.id != AxiId, or if r.last != (counter == len);
    - the counter increments.
  - The handshake with r.last = 1 goes to RSP, even if it arrives early.
  - When the counter reaches len and r.last is 0, the block keeps accepting beats until r.last. The counter saturates at 255, and SLVERR is merged.
- RSP:
  - rsp_valid_o = 1 and rsp_resp_o = acc.
  - On rsp_ready_i, return to IDLE. A new command is accepted no earlier than the cycle after.
- Response precedence is axi_pkg::resp_precedence (DECERR > SLVERR > OKAY > EXOKAY).
- Minimum latency, zero-wait subordinate, len = 0:
  - write: command to rsp_valid in 4 cycles (AW, W, B, RSP);
  - read: command to rsp_valid in 3 cycles (AR, R, RSP).
- Simultaneous events:
  - cmd_valid_i while busy is ignored (cmd_ready_o = 0).
  - b_valid or r_valid outside state B or R is not accepted (ready = 0).

Test Plan:
- Write, addr 0x1000, len 3, 64-bit bus, strb 0xFF, zero-wait subordinate:
  - AW shows addr 0x1000, len 3, size 3, INCR.
  - 4 W beats, with last only on beat 3.
  - B OKAY gives rsp_resp_o = OKAY.
- Read, addr 0x2004, len 0: AR addr is 0x2000, rdata_last_o = 1, rsp_resp_o = OKAY.
- Read, len 7, with the subordinate returning SLVERR on beat 2 and rdata_ready_i toggling every other cycle:
  - all 8 beats are delivered in order;
  - r_ready mirrors rdata_ready_i;
  - rsp_resp_o = SLVERR.
- Command at addr 0xFF8, len 1 (crosses 4 KiB):
  - no aw_valid or ar_valid is ever asserted;
  - rsp_valid_o rises 1 cycle after the command handshake, with SLVERR.
- Read, len 3, with the subordinate asserting r.last on beat 1: exit after beat 1, rsp_resp_o = SLVERR.
- Assert rst_ni = 0 mid-W-burst:
  - w_valid, aw_valid and rsp_valid_o go to 0 asynchronously;
  - after release, cmd_ready_o = 1 and a new read completes with OKAY.
